// File: rtl/wb_arbiter_if.sv
// wb_arbiter_if: producer, register-file and busy signals of the writeback arbiter.
// Forwarding signals exist only when WB_BYPASS_EN is defined.
interface wb_arbiter_if #(parameter int XLEN = 32);
  logic            alu_valid;
  logic            alu_ready;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            lsu_valid;
  logic            lsu_ready;
  logic [4:0]      lsu_rd;
  logic [XLEN-1:0] lsu_data;
  logic [4:0]      rf_rd;
  logic [XLEN-1:0] rf_wdata;
  logic            rf_write_en;
  logic            busy;
`ifdef WB_BYPASS_EN
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic            fwdA_hit;
  logic            fwdB_hit;
  logic [XLEN-1:0] fwdA_data;
  logic [XLEN-1:0] fwdB_data;
`endif
  modport master (
    output alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
    input  alu_ready, lsu_ready, rf_rd, rf_wdata, rf_write_en, busy
`ifdef WB_BYPASS_EN
    , output rs1, rs2,
    input  fwdA_hit, fwdB_hit, fwdA_data, fwdB_data
`endif
  );
  modport slave (
    input  alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
    output alu_ready, lsu_ready, rf_rd, rf_wdata, rf_write_en, busy
`ifdef WB_BYPASS_EN
    , input rs1, rs2,
    output fwdA_hit, fwdB_hit, fwdA_data, fwdB_data
`endif
  );
endinterface

// File: rtl/wb_arbiter.sv
// wb_arbiter: buffers ALU/LSU results in per-source FIFOs and drives a registered RF write port
// round-robin. Defining WB_BYPASS_EN adds combinational forwarding of the pending write to rs1/rs2.
module wb_arbiter #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input logic        clock,
  input logic        reset,
  wb_arbiter_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  typedef enum logic {PREF_ALU, PREF_LSU} pref_t;
  pref_t           pref, pref_next;
  logic [4:0]      rd_mem   [2][DEPTH];
  logic [XLEN-1:0] data_mem [2][DEPTH];
  logic [AW-1:0]   wp [2];
  logic [AW-1:0]   rp [2];
  logic [CW-1:0]   cnt [2];
  logic [4:0]      in_rd [2];
  logic [XLEN-1:0] in_data [2];
  logic [1:0]      valid, full, nempty, push, pop;
  logic            gnt, sel;
  logic [4:0]      rf_rd;
  logic [XLEN-1:0] rf_wdata;
  logic            rf_we;
  assign valid      = {bus.lsu_valid, bus.alu_valid};
  assign in_rd[0]   = bus.alu_rd;
  assign in_rd[1]   = bus.lsu_rd;
  assign in_data[0] = bus.alu_data;
  assign in_data[1] = bus.lsu_data;
  // index 0 is the ALU, index 1 the LSU; sel picks the granted source
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      full[i]   = cnt[i] == CW'(DEPTH);
      nempty[i] = cnt[i] != '0;
    end
    push      = valid & ~full;
    gnt       = |nempty;
    sel       = &nempty ? (pref == PREF_LSU) : nempty[1];
    pop       = gnt ? (sel ? 2'b10 : 2'b01) : 2'b00;
    pref_next = &nempty ? (sel ? PREF_ALU : PREF_LSU) : pref;
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      pref     <= PREF_ALU;
      rf_rd    <= '0;
      rf_wdata <= '0;
      rf_we    <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        wp[i]  <= '0;
        rp[i]  <= '0;
        cnt[i] <= '0;
      end
    end else begin
      pref <= pref_next;
      for (int i = 0; i < 2; i++) begin
        wp[i]  <= wp[i] + AW'(push[i]);
        rp[i]  <= rp[i] + AW'(pop[i]);
        cnt[i] <= cnt[i] + CW'(push[i]) - CW'(pop[i]);
      end
      rf_we <= gnt && rd_mem[sel][rp[sel]] != '0;
      if (gnt) begin
        rf_rd    <= rd_mem[sel][rp[sel]];
        rf_wdata <= data_mem[sel][rp[sel]];
      end
    end
  always_ff @(posedge clock)
    for (int i = 0; i < 2; i++)
      if (push[i]) begin
        rd_mem[i][wp[i]]   <= in_rd[i];
        data_mem[i][wp[i]] <= in_data[i];
      end
  assign bus.alu_ready   = !full[0];
  assign bus.lsu_ready   = !full[1];
  assign bus.rf_rd       = rf_rd;
  assign bus.rf_wdata    = rf_wdata;
  assign bus.rf_write_en = rf_we;
  assign bus.busy        = gnt | rf_we;
`ifdef WB_BYPASS_EN
  assign bus.fwdA_hit  = rf_we && rf_rd == bus.rs1 && bus.rs1 != '0;
  assign bus.fwdB_hit  = rf_we && rf_rd == bus.rs2 && bus.rs2 != '0;
  assign bus.fwdA_data = rf_wdata;
  assign bus.fwdB_data = rf_wdata;
`endif
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed scenarios plus randomized traffic checked against a queue-based model.
module tb_wb_arbiter;
  localparam int XLEN  = 32;
  localparam int DEPTH = 2;
  typedef struct {logic [4:0] rd; logic [XLEN-1:0] data;} ent_t;
  logic clock = 1'b0;
  logic reset = 1'b1;
  wb_arbiter_if #(.XLEN(XLEN)) ifc ();
  wb_arbiter #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (.clock(clock), .reset(reset), .bus(ifc.slave));
  always #5 clock = ~clock;
  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  ent_t qa[$];
  ent_t ql[$];
  bit pref_lsu = 0;
  logic exp_we = 0;
  logic [4:0] exp_rd = '0;
  logic [XLEN-1:0] exp_wdata = '0;
  logic [4:0] wlog[$];
  int wcyc[$];
  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask
  task automatic offer_alu(logic [4:0] rd, logic [XLEN-1:0] d);
    ifc.alu_valid = 1'b1; ifc.alu_rd = rd; ifc.alu_data = d;
  endtask
  task automatic offer_lsu(logic [4:0] rd, logic [XLEN-1:0] d);
    ifc.lsu_valid = 1'b1; ifc.lsu_rd = rd; ifc.lsu_data = d;
  endtask
  // One clock: check outputs against the model, advance the model, then let the edge happen.
  task automatic cycle();
    bit acc_a, acc_l, g_any, g_lsu;
    ent_t e;
    @(negedge clock);
    check("alu_ready", ifc.alu_ready, qa.size() < DEPTH);
    check("lsu_ready", ifc.lsu_ready, ql.size() < DEPTH);
    check("rf_write_en", ifc.rf_write_en, exp_we);
    check("rf_rd", ifc.rf_rd, exp_rd);
    check("rf_wdata", ifc.rf_wdata, exp_wdata);
    check("busy", ifc.busy, qa.size() != 0 || ql.size() != 0 || exp_we);
`ifdef WB_BYPASS_EN
    check("fwdA_hit", ifc.fwdA_hit, exp_we && exp_rd == ifc.rs1 && ifc.rs1 != 0);
    check("fwdB_hit", ifc.fwdB_hit, exp_we && exp_rd == ifc.rs2 && ifc.rs2 != 0);
    check("fwdA_data", ifc.fwdA_data, exp_wdata);
`endif
    acc_a = ifc.alu_valid && qa.size() < DEPTH;
    acc_l = ifc.lsu_valid && ql.size() < DEPTH;
    g_any = qa.size() != 0 || ql.size() != 0;
    g_lsu = (qa.size() != 0 && ql.size() != 0) ? pref_lsu : ql.size() != 0;
    if (qa.size() != 0 && ql.size() != 0) pref_lsu = !pref_lsu;
    if (g_any) begin
      e = g_lsu ? ql.pop_front() : qa.pop_front();
      exp_rd = e.rd; exp_wdata = e.data; exp_we = e.rd != 0;
    end else exp_we = 1'b0;
    if (acc_a) qa.push_back('{ifc.alu_rd, ifc.alu_data});
    if (acc_l) ql.push_back('{ifc.lsu_rd, ifc.lsu_data});
    @(posedge clock);
    #1;
    cyc++;
    if (acc_a) ifc.alu_valid = 1'b0;
    if (acc_l) ifc.lsu_valid = 1'b0;
    if (ifc.rf_write_en) begin wlog.push_back(ifc.rf_rd); wcyc.push_back(cyc); end
  endtask
  task automatic do_reset();
    reset = 1'b1;
    ifc.alu_valid = 1'b0; ifc.lsu_valid = 1'b0;
    qa.delete(); ql.delete();
    pref_lsu = 0; exp_we = 0; exp_rd = '0; exp_wdata = '0;
    #1;
    check("rst_we", ifc.rf_write_en, 0);
    check("rst_busy", ifc.busy, 0);
    check("rst_rd", ifc.rf_rd, 0);
    check("rst_wdata", ifc.rf_wdata, 0);
    @(posedge clock);
    #2 reset = 1'b0;
    #1;
    check("rst_alu_ready", ifc.alu_ready, 1);
    check("rst_lsu_ready", ifc.lsu_ready, 1);
  endtask
  task automatic drain(int n);
    ifc.alu_valid = 1'b0; ifc.lsu_valid = 1'b0;
    repeat (n) cycle();
  endtask
  initial begin
    int na, nl, guard, rate_a, rate_l;
    ifc.alu_valid = 0; ifc.alu_rd = '0; ifc.alu_data = '0;
    ifc.lsu_valid = 0; ifc.lsu_rd = '0; ifc.lsu_data = '0;
`ifdef WB_BYPASS_EN
    ifc.rs1 = '0; ifc.rs2 = '0;
`endif
    do_reset();
    // single ALU write: visible after the second edge, gone after the third
    offer_alu(5'd5, 32'hA5A5_0001);
    cycle(); cycle();
    check("t1_we", ifc.rf_write_en, 1);
    check("t1_rd", ifc.rf_rd, 5);
    check("t1_wdata", ifc.rf_wdata, 32'hA5A5_0001);
    cycle();
    check("t1_we_low", ifc.rf_write_en, 0);
    drain(2);
    // both sources pushing continuously alternate ALU/LSU, each in push order
    wlog.delete(); wcyc.delete();
    na = 0; nl = 0; guard = 0;
    while (wlog.size() < 4 && guard < 20) begin
      if (!ifc.alu_valid) begin na++; offer_alu(5'(na), 32'(100 + na)); end
      if (!ifc.lsu_valid) begin nl++; offer_lsu(5'(10 + nl), 32'(200 + nl)); end
      cycle();
      guard++;
    end
    check("t2_count", wlog.size() >= 4, 1);
    if (wlog.size() >= 4) begin
      check("t2_w0", wlog[0], 1);
      check("t2_w1", wlog[1], 11);
      check("t2_w2", wlog[2], 2);
      check("t2_w3", wlog[3], 12);
    end
    drain(8);
    // three LSU pushes back to back drain one per cycle without stalling
    wlog.delete(); wcyc.delete();
    for (int k = 0; k < 3; k++) begin
      check("t3_lsu_ready", ifc.lsu_ready, 1);
      offer_lsu(5'(20 + k), 32'(300 + k));
      cycle();
    end
    drain(2);
    check("t3_writes", wlog.size(), 3);
    if (wlog.size() == 3) begin
      check("t3_consec0", wcyc[1] - wcyc[0], 1);
      check("t3_consec1", wcyc[2] - wcyc[1], 1);
      check("t3_last_rd", wlog[2], 22);
    end
    // rd=0 is consumed but never written
    wlog.delete();
    offer_alu(5'd0, 32'hFFFF_FFFF);
    cycle();
    check("t4_busy1", ifc.busy, 1);
    cycle();
    check("t4_we", ifc.rf_write_en, 0);
    check("t4_busy0", ifc.busy, 0);
    check("t4_nowrite", wlog.size(), 0);
    // reset in the middle of a drain discards everything
    repeat (3) begin
      if (!ifc.alu_valid) offer_alu(5'd9, $urandom);
      if (!ifc.lsu_valid) offer_lsu(5'd19, $urandom);
      cycle();
    end
    check("t5_we_before", ifc.rf_write_en, 1);
    do_reset();
    wlog.delete();
    drain(5);
    check("t5_no_stale", wlog.size(), 0);
`ifdef WB_BYPASS_EN
    offer_alu(5'd7, 32'h1234);
    cycle(); cycle();
    ifc.rs1 = 5'd7; ifc.rs2 = 5'd0;
    #1;
    check("byp_a_hit", ifc.fwdA_hit, 1);
    check("byp_a_data", ifc.fwdA_data, 32'h1234);
    check("byp_b_hit", ifc.fwdB_hit, 0);
    drain(3);
`endif
    // randomized traffic with varying offer rates and occasional resets
    rate_a = 50; rate_l = 50;
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) begin rate_a = $urandom_range(0, 100); rate_l = $urandom_range(0, 100); end
      if (!ifc.alu_valid && $urandom_range(0, 99) < rate_a)
        offer_alu($urandom_range(0, 3) == 0 ? 5'd0 : 5'($urandom), $urandom);
      if (!ifc.lsu_valid && $urandom_range(0, 99) < rate_l)
        offer_lsu($urandom_range(0, 3) == 0 ? 5'd0 : 5'($urandom), $urandom);
`ifdef WB_BYPASS_EN
      ifc.rs1 = $urandom_range(0, 1) ? exp_rd : 5'($urandom);
      ifc.rs2 = $urandom_range(0, 1) ? exp_rd : 5'($urandom);
`endif
      if ($urandom_range(0, 499) == 0) do_reset();
      else cycle();
    end
    drain(6);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
